decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  Decode stage directly downstream of fetch. Accepts the 16-bit instruction fetch presents as
//  instruction_code_high/low and buffers it in a 2-entry queue. Decodes register and immediate
//  fields, merges two-word LDI_LONG instructions, and presents one registered decoded op per
//  valid/ready handshake to execute. Drives fetch_ready back to gate fetch's enable.
// PARAMETERS
//  QDEPTH      2    instruction queue depth, power of 2, >=2
//  IMM_W       16   width of dec_imm
// PORTS
//  clk                    in   1   single clock, rising edge
//  reset                  in   1   async, active-low; all state cleared while low
//  instruction_code_high  in   8   fetched word [15:8]
//  instruction_code_low   in   8   fetched word [7:0]
//  fetch_valid            in   1   fetched word present this cycle
//  fetch_ready            out  1   queue can accept; reset 0, 1 from first cycle after reset release
//  flush                  in   1   discard queue, FSM and output register (branch/redirect)
//  exec_ready             in   1   execute consumes dec_* this cycle
//  dec_valid              out  1   decoded op valid; reset 0
//  dec_opcode             out  4   word[15:12]; reset 0
//  dec_rd/dec_ra/dec_rb   out  3   word[11:9]/[8:6]/[5:3]; reset 0
//  dec_imm                out  16  sign-extended word[7:0], or full 2nd word for LDI_LONG; reset 0
//  dec_illegal            out  1   reserved opcode flag (see CONFIGURATION); reset 0
// BEHAVIOUR
//  - Push: fetch_valid && fetch_ready, where fetch_ready = !full (registered). No pass-through
//    when full and popping in the same cycle.
//  - Pop: head consumed when output reg loadable: load_en = !dec_valid || exec_ready.
//  - Latency: word pushed at edge N -> in queue after N -> dec_valid after edge N+1 (2 cycles).
//  - FSM states: IDLE, WAIT_IMM.
//    IDLE, head opcode != 4'hF, load_en: pop, load output reg, dec_valid=1.
//    IDLE, head opcode == 4'hF (LDI_LONG): pop, latch rd, go WAIT_IMM.
//      Output reg is not loaded, and dec_valid drops to 0 once the current op is taken.
//    WAIT_IMM, queue non-empty, load_en: pop, dec_opcode=4'hF, dec_rd=latched rd, ra=rb=0,
//      dec_imm=popped word, dec_valid=1, go IDLE.
//      Queue empty: hold WAIT_IMM indefinitely.
//  - dec_valid && !exec_ready: all dec_* held stable.
//  - Empty queue + exec_ready: dec_valid falls to 0 next edge.
//  - Full queue: fetch_ready=0; fetch_valid ignored, no overwrite.
//  - Counters: pointers wrap modulo QDEPTH. count is clog2(QDEPTH)+1 bits.
//    Simultaneous push+pop leaves count unchanged.
//  - flush (sync, highest priority): next edge count=0, FSM=IDLE, dec_valid=0.
//    Same-cycle push and pop are discarded. fetch_ready=1 the cycle after.
//  - Reset asserted mid-operation (including in WAIT_IMM): immediate return to reset values.
//    The half-merged LDI_LONG is lost.
// CONFIGURATION
//  DECODE_ILLEGAL_TRAP_EN defined: opcode 4'hE is reserved.
//    Decoded normally, with dec_illegal=1 for that op.
//  Undefined: dec_illegal tied 0; opcode 4'hE is rewritten to 4'h0 (NOP), fields zeroed.
// STRUCTURE
//  - decode_pkg:
//    - opcode localparams OP_NOP=4'h0, OP_RSVD=4'hE, OP_LDI_LONG=4'hF
//    - field bit positions
//    - FSM state encoding
//  - Sub-module instr_queue: QDEPTH x 16 FIFO with push/pop/flush, full/empty, count.
//    The top level holds the FSM, field extraction and output register.
// TESTING
//  1 Reset low 2 cycles, release:
//    - dec_valid=0 throughout reset; fetch_ready=1 next cycle.
//  2 Push 16'h1A4C, exec_ready=1:
//    - 2 cycles later dec_valid=1, opcode=1, rd=5, ra=1, rb=1, imm=16'h004C.
//    - Push 16'h3280 -> imm=16'hFF80.
//  3 Push 16'hF600 then 16'hBEEF:
//    - exactly one op: opcode=F, rd=3, imm=16'hBEEF.
//    - Idle gap of 3 cycles between the words -> same result.
//  4 exec_ready=0, push 4 words:
//    - fetch_ready=0 after the 3rd accepted word (1 out-reg + 2 queue); 4th ignored.
//    - Raise exec_ready -> the 3 words emerge in order, no loss or duplicate.
//  5 flush in WAIT_IMM with 1 word queued:
//    - next cycle dec_valid=0, FSM=IDLE.
//    - Push 16'h1000 -> opcode=1, not merged as immediate.
//  6 Push 16'hE123 in both builds:
//    - with macro: dec_illegal=1, opcode=E.
//    - without: opcode=0, dec_illegal=0.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared definitions for the decode stage: opcode values, instruction field
// positions, the decode FSM state encoding and a field-unpacking helper.
package decode_pkg;

    localparam int INSTR_W = 16;

    // Opcodes with special handling in decode.
    localparam logic [3:0] OP_NOP      = 4'h0;
    localparam logic [3:0] OP_RSVD     = 4'hE;
    localparam logic [3:0] OP_LDI_LONG = 4'hF;

    // Least-significant bit of each field inside a 16-bit instruction word.
    localparam int OPC_LSB  = 12;  // [15:12]
    localparam int RD_LSB   = 9;   // [11:9]
    localparam int RA_LSB   = 6;   // [8:6]
    localparam int RB_LSB   = 3;   // [5:3]
    localparam int IMM8_LSB = 0;   // [7:0], overlaps rb

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_WAIT_IMM = 1'b1   // LDI_LONG first word taken, waiting for its immediate word
    } dec_state_e;

    typedef struct packed {
        logic [3:0] opcode;
        logic [2:0] rd;
        logic [2:0] ra;
        logic [2:0] rb;
        logic [7:0] imm8;
    } instr_fields_t;

    function automatic instr_fields_t unpack_instr(input logic [INSTR_W-1:0] w);
        instr_fields_t f;
        f.opcode = w[OPC_LSB  +: 4];
        f.rd     = w[RD_LSB   +: 3];
        f.ra     = w[RA_LSB   +: 3];
        f.rb     = w[RB_LSB   +: 3];
        f.imm8   = w[IMM8_LSB +: 8];
        return f;
    endfunction

endpackage

// File: rtl/decode_stage_instr_queue.sv
// instr_queue: small synchronous FIFO holding fetched instruction words.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   push, wdata     write a word (ignored when full)
//   pop, rdata      advance the head (ignored when empty); rdata is the current head
//   flush           synchronous clear, dominates push and pop
//   full, empty     occupancy flags derived from the internal count
module instr_queue #(
    parameter int DEPTH = 2,   // power of 2, >= 2
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // NOTE: the storage is only DEPTH words, so it is reset with the pointers;
    // this keeps rdata defined straight out of reset at negligible cost.
    // NOTE: sequential state is always written with non-blocking assignments
    // so every flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;  // DEPTH is a power of 2: natural wrap
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;       // idle, or push+pop cancel out
            endcase
        end
    end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: decode stage directly downstream of fetch.
// Buffers fetched 16-bit words in instr_queue, extracts register/immediate
// fields, merges two-word LDI_LONG instructions and presents one registered
// decoded op per dec_valid/exec_ready handshake.
// Ports:
//   clk, reset                     clock, async active-low reset
//   instruction_code_high/low      fetched word [15:8] / [7:0]
//   fetch_valid, fetch_ready       fetch handshake (ready = queue not full)
//   flush                          drop queue, FSM progress and current output op
//   exec_ready                     execute takes dec_* this cycle
//   dec_valid, dec_opcode, dec_rd, dec_ra, dec_rb, dec_imm, dec_illegal
//                                  registered decoded op
// Build option: define DECODE_ILLEGAL_TRAP_EN to pass the reserved opcode 4'hE
// through with dec_illegal=1; otherwise it is rewritten to a NOP with zeroed fields.
module decode_stage
    import decode_pkg::*;
#(
    parameter int QDEPTH = 2,
    parameter int IMM_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       instruction_code_high,
    input  logic [7:0]       instruction_code_low,
    input  logic             fetch_valid,
    output logic             fetch_ready,
    input  logic             flush,
    input  logic             exec_ready,
    output logic             dec_valid,
    output logic [3:0]       dec_opcode,
    output logic [2:0]       dec_rd,
    output logic [2:0]       dec_ra,
    output logic [2:0]       dec_rb,
    output logic [IMM_W-1:0] dec_imm,
    output logic             dec_illegal
);

    logic [INSTR_W-1:0] fetch_word;
    logic [INSTR_W-1:0] q_head;
    logic               q_push;
    logic               q_pop;
    logic               q_full;
    logic               q_empty;
    logic               rst_done;

    dec_state_e    state_q;
    dec_state_e    state_d;
    instr_fields_t head_f;
    logic          load_en;
    logic          load_op;
    logic          load_long;
    logic          latch_rd;
    logic [2:0]    rd_latched;

    logic [3:0]       op_opcode;
    logic [2:0]       op_rd;
    logic [2:0]       op_ra;
    logic [2:0]       op_rb;
    logic [IMM_W-1:0] op_imm;
    logic             op_illegal;

    assign fetch_word = {instruction_code_high, instruction_code_low};

    // fetch_ready stays low during reset and for the cycle the reset is released.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_done <= 1'b0;
        end else begin
            rst_done <= 1'b1;
        end
    end

    assign fetch_ready = rst_done && !q_full;
    assign q_push      = fetch_valid && fetch_ready;

    instr_queue #(
        .DEPTH (QDEPTH),
        .WIDTH (INSTR_W)
    ) u_queue (
        .clk   (clk),
        .rst_n (reset),
        .push  (q_push),
        .wdata (fetch_word),
        .pop   (q_pop),
        .flush (flush),
        .rdata (q_head),
        .full  (q_full),
        .empty (q_empty)
    );

    assign head_f  = unpack_instr(q_head);
    assign load_en = !dec_valid || exec_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        q_pop     = 1'b0;
        load_op   = 1'b0;
        load_long = 1'b0;
        latch_rd  = 1'b0;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!q_empty) begin
                        if (head_f.opcode == OP_LDI_LONG) begin
                            // First word carries only rd; it never touches the output
                            // register, so it can be taken even while execute stalls.
                            q_pop    = 1'b1;
                            latch_rd = 1'b1;
                            state_d  = ST_WAIT_IMM;
                        end else if (load_en) begin
                            q_pop   = 1'b1;
                            load_op = 1'b1;
                        end
                    end
                end
                ST_WAIT_IMM: begin
                    if (!q_empty && load_en) begin
                        q_pop     = 1'b1;
                        load_long = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Field extraction for a single-word op at the queue head.
    always_comb begin
        op_opcode  = head_f.opcode;
        op_rd      = head_f.rd;
        op_ra      = head_f.ra;
        op_rb      = head_f.rb;
        op_imm     = {{(IMM_W-8){head_f.imm8[7]}}, head_f.imm8};
        op_illegal = 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
        op_illegal = (head_f.opcode == OP_RSVD);
`else
        if (head_f.opcode == OP_RSVD) begin
            op_opcode = OP_NOP;
            op_rd     = '0;
            op_ra     = '0;
            op_rb     = '0;
            op_imm    = '0;
        end
`endif
    end

    // Output register: loads only when empty or being consumed, so a stalled
    // op stays stable on dec_*.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dec_valid   <= 1'b0;
            dec_opcode  <= '0;
            dec_rd      <= '0;
            dec_ra      <= '0;
            dec_rb      <= '0;
            dec_imm     <= '0;
            dec_illegal <= 1'b0;
            rd_latched  <= '0;
        end else if (flush) begin
            dec_valid  <= 1'b0;
            rd_latched <= '0;
        end else begin
            if (latch_rd) begin
                rd_latched <= head_f.rd;
            end
            if (load_op) begin
                dec_valid   <= 1'b1;
                dec_opcode  <= op_opcode;
                dec_rd      <= op_rd;
                dec_ra      <= op_ra;
                dec_rb      <= op_rb;
                dec_imm     <= op_imm;
                dec_illegal <= op_illegal;
            end else if (load_long) begin
                dec_valid   <= 1'b1;
                dec_opcode  <= OP_LDI_LONG;
                dec_rd      <= rd_latched;
                dec_ra      <= '0;
                dec_rb      <= '0;
                dec_imm     <= IMM_W'(q_head);
                dec_illegal <= 1'b0;
            end else if (load_en) begin
                // Current op (if any) is taken and nothing replaces it.
                dec_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  instruction_code_high;
    logic [7:0]  instruction_code_low;
    logic        fetch_valid;
    logic        fetch_ready;
    logic        flush;
    logic        exec_ready;
    logic        dec_valid;
    logic [3:0]  dec_opcode;
    logic [2:0]  dec_rd;
    logic [2:0]  dec_ra;
    logic [2:0]  dec_rb;
    logic [15:0] dec_imm;
    logic        dec_illegal;

    int checks = 0;
    int errors = 0;

    decode_stage #(
        .QDEPTH (2),
        .IMM_W  (16)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .instruction_code_high (instruction_code_high),
        .instruction_code_low  (instruction_code_low),
        .fetch_valid           (fetch_valid),
        .fetch_ready           (fetch_ready),
        .flush                 (flush),
        .exec_ready            (exec_ready),
        .dec_valid             (dec_valid),
        .dec_opcode            (dec_opcode),
        .dec_rd                (dec_rd),
        .dec_ra                (dec_ra),
        .dec_rb                (dec_rb),
        .dec_imm               (dec_imm),
        .dec_illegal           (dec_illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle so outputs are sampled away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [15:0] w);
        {instruction_code_high, instruction_code_low} = w;
        fetch_valid = 1'b1;
        step();
        fetch_valid = 1'b0;
    endtask

    logic [3:0] got_ops [4];
    int         n_ops;

    initial begin
        reset       = 1'b0;
        fetch_valid = 1'b0;
        flush       = 1'b0;
        exec_ready  = 1'b0;
        {instruction_code_high, instruction_code_low} = 16'h0000;

        // 1: reset held two cycles, then released
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst_dec_valid", dec_valid, 0);
            check("rst_fetch_ready", fetch_ready, 0);
        end
        reset = 1'b1;
        step();
        check("post_rst_fetch_ready", fetch_ready, 1);
        check("post_rst_dec_valid", dec_valid, 0);

        // 2: plain ops, two-cycle latency
        exec_ready = 1'b1;
        push_word(16'h1A4C);
        check("lat_not_yet", dec_valid, 0);
        step();
        check("op1_valid", dec_valid, 1);
        check("op1_opcode", dec_opcode, 4'h1);
        check("op1_rd", dec_rd, 3'd5);
        check("op1_ra", dec_ra, 3'd1);
        check("op1_rb", dec_rb, 3'd1);
        check("op1_imm", dec_imm, 16'h004C);
        push_word(16'h3280);
        check("drain_gap", dec_valid, 0);
        step();
        check("op2_valid", dec_valid, 1);
        check("op2_opcode", dec_opcode, 4'h3);
        check("op2_imm_sext", dec_imm, 16'hFF80);
        step();
        check("empty_drop_valid", dec_valid, 0);

        // 3: LDI_LONG back to back
        push_word(16'hF600);
        check("ldi_w1_no_out", dec_valid, 0);
        push_word(16'hBEEF);
        check("ldi_w2_no_out", dec_valid, 0);
        step();
        check("ldi_valid", dec_valid, 1);
        check("ldi_opcode", dec_opcode, 4'hF);
        check("ldi_rd", dec_rd, 3'd3);
        check("ldi_ra", dec_ra, 3'd0);
        check("ldi_rb", dec_rb, 3'd0);
        check("ldi_imm", dec_imm, 16'hBEEF);
        step();
        check("ldi_once", dec_valid, 0);

        // 3b: LDI_LONG with a 3-cycle gap between words
        push_word(16'hF600);
        for (int i = 0; i < 3; i++) begin
            step();
            check("ldi_gap_no_out", dec_valid, 0);
        end
        push_word(16'hBEEF);
        check("ldi_gap_w2_no_out", dec_valid, 0);
        step();
        check("ldi_gap_valid", dec_valid, 1);
        check("ldi_gap_opcode", dec_opcode, 4'hF);
        check("ldi_gap_rd", dec_rd, 3'd3);
        check("ldi_gap_imm", dec_imm, 16'hBEEF);
        step();
        check("ldi_gap_once", dec_valid, 0);

        // 4: back-pressure, queue fills after three words
        exec_ready = 1'b0;
        push_word(16'h2111);
        push_word(16'h3222);
        check("bp_ready_2", fetch_ready, 1);
        push_word(16'h4333);
        check("bp_full_ready", fetch_ready, 0);
        check("bp_hold_valid", dec_valid, 1);
        check("bp_hold_opcode", dec_opcode, 4'h2);
        {instruction_code_high, instruction_code_low} = 16'h5444;
        fetch_valid = 1'b1;
        step();
        fetch_valid = 1'b0;
        check("bp_still_full", fetch_ready, 0);
        check("bp_stable_opcode", dec_opcode, 4'h2);
        check("bp_stable_rd", dec_rd, 3'd0);
        exec_ready = 1'b1;
        n_ops = 0;
        for (int i = 0; i < 8; i++) begin
            if (dec_valid) begin
                if (n_ops < 4) got_ops[n_ops] = dec_opcode;
                n_ops++;
            end
            step();
        end
        check("bp_op_count", n_ops, 3);
        check("bp_order_0", got_ops[0], 4'h2);
        check("bp_order_1", got_ops[1], 4'h3);
        check("bp_order_2", got_ops[2], 4'h4);
        check("bp_ready_again", fetch_ready, 1);

        // 5: flush while in WAIT_IMM with one word queued
        exec_ready = 1'b0;
        push_word(16'h2000);
        push_word(16'hF600);
        push_word(16'hBEEF);
        check("fl_pre_valid", dec_valid, 1);
        check("fl_pre_opcode", dec_opcode, 4'h2);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("fl_valid_cleared", dec_valid, 0);
        check("fl_ready", fetch_ready, 1);
        exec_ready = 1'b1;
        push_word(16'h1000);
        step();
        check("fl_after_valid", dec_valid, 1);
        check("fl_after_opcode", dec_opcode, 4'h1);
        check("fl_after_imm", dec_imm, 16'h0000);
        step();
        check("fl_after_drop", dec_valid, 0);

        // 6: reserved opcode
        push_word(16'hE123);
        step();
        check("rsvd_valid", dec_valid, 1);
`ifdef DECODE_ILLEGAL_TRAP_EN
        check("rsvd_opcode", dec_opcode, 4'hE);
        check("rsvd_illegal", dec_illegal, 1);
        check("rsvd_ra", dec_ra, 3'd4);
        check("rsvd_imm", dec_imm, 16'h0023);
`else
        check("rsvd_opcode", dec_opcode, 4'h0);
        check("rsvd_illegal", dec_illegal, 0);
        check("rsvd_ra", dec_ra, 3'd0);
        check("rsvd_imm", dec_imm, 16'h0000);
`endif
        step();

        // 7: reset while waiting for the LDI_LONG immediate
        push_word(16'hF600);
        step();
        reset = 1'b0;
        #1;
        check("mid_rst_valid", dec_valid, 0);
        check("mid_rst_ready", fetch_ready, 0);
        step();
        reset = 1'b1;
        step();
        check("mid_rst_ready_back", fetch_ready, 1);
        push_word(16'hBEEF);
        step();
        check("mid_rst_valid_b", dec_valid, 1);
        check("mid_rst_not_merged", dec_opcode, 4'hB);
        check("mid_rst_rd", dec_rd, 3'd7);
        check("mid_rst_imm", dec_imm, 16'hFFEF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
